// File: rtl/router_pkg.sv
// Shared types and constants for the mesh router traffic sources.
// Contents: flit type codes, destination pattern codes, LFSR constants and
// a single-step helper for the 16-bit Galois LFSR.
package router_pkg;

  // Two-bit type field carried in the top bits of every flit.
  typedef enum logic [1:0] {
    BODY   = 2'b00,
    HEAD   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    UNIFORM   = 2'd0,
    TRANSPOSE = 2'd1,
    HOTSPOT   = 2'd2,
    FIXED     = 2'd3
  } traffic_mode_e;

  localparam logic [15:0] LFSR_MASK         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // Right-shifting Galois step: the bit falling out of bit 0 folds the mask back in.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/tg_lfsr16.sv
// 16-bit Galois LFSR used as the random source of the traffic generator.
// Ports:
//   clk     - clock
//   reset   - synchronous active-high reset, loads the seed
//   en_i    - advance the LFSR by one step this cycle
//   state_o - current 16-bit LFSR state
module tg_lfsr16
  import router_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  output logic [15:0] state_o
);

  // An all-zero state would lock the LFSR, so a zero seed falls back to the default.
  localparam logic [15:0] SeedEff = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

  logic [15:0] lfsr_d, lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SeedEff;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/traffic_gen_param.sv
// Synthetic-traffic source for the LOCAL port of one mesh router.
// Injects PKT_LEN-flit packets under on/off flow control with a configurable
// injection rate, destination pattern and packet budget.
// Ports:
//   clk            - clock
//   reset          - synchronous active-high reset
//   i_start        - level, high permits new packets
//   i_send         - router can accept a flit this cycle
//   o_flit         - current flit
//   o_transmit     - o_flit valid
//   o_busy         - packet in progress
//   o_done         - packet budget exhausted
//   o_pkts_sent    - completed packets (saturating)
//   o_flits_sent   - transferred flits (saturating)
//   o_stall_cycles - cycles offering a flit that the router refused (saturating)
module traffic_gen_param
  import router_pkg::*;
#(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLUMNS  = 4,
  parameter int unsigned XADDR    = 0,
  parameter int unsigned YADDR    = 0,
  parameter int unsigned FLIT_W   = 32,
  parameter int unsigned PKT_LEN  = 4,
  parameter int unsigned INJ_RATE = 64,
  parameter int unsigned MODE     = 0,
  parameter int unsigned HOT_X    = 0,
  parameter int unsigned HOT_Y    = 0,
  parameter int unsigned MAX_PKTS = 0,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_send,
  output logic [FLIT_W-1:0] o_flit,
  output logic              o_transmit,
  output logic              o_busy,
  output logic              o_done,
  output logic [31:0]       o_pkts_sent,
  output logic [31:0]       o_flits_sent,
  output logic [31:0]       o_stall_cycles
);

  localparam int unsigned XW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned YW  = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int unsigned IdW = FLIT_W - 2 - 2 * XW - 2 * YW;

  localparam logic [XW-1:0] SrcX    = XW'(XADDR);
  localparam logic [YW-1:0] SrcY    = YW'(YADDR);
  localparam logic [XW-1:0] HotX    = XW'(HOT_X);
  localparam logic [YW-1:0] HotY    = YW'(HOT_Y);
  localparam logic [8:0]    RateThr = 9'(INJ_RATE);
  localparam logic [7:0]    LastSeq = 8'(PKT_LEN - 1);
  localparam logic [1:0]    ModeSel = 2'(MODE);

  typedef enum logic [2:0] {StIdle, StWait, StHead, StBody, StDone} state_e;

  state_e      state_d, state_q;
  logic        start_q;
  logic [XW-1:0] dest_x_d, dest_x_q;
  logic [YW-1:0] dest_y_d, dest_y_q;
  logic [15:0] pkt_id_d, pkt_id_q;
  logic [7:0]  seq_d, seq_q;
  logic [31:0] pkts_d, pkts_q, flits_d, flits_q, stall_d, stall_q;

  logic [15:0] lfsr;
  logic        lfsr_en;

  tg_lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .en_i   (lfsr_en),
    .state_o(lfsr)
  );

  assign lfsr_en = (state_q != StIdle) && (state_q != StDone);

  // Candidate destination from the random byte; the y draw uses a nibble rotate
  // so x and y are not trivially correlated.
  logic [7:0]    rnd, rnd_rot;
  logic [XW-1:0] cand_x;
  logic [YW-1:0] cand_y;
  logic          inject, self_dest;

  assign rnd     = lfsr[15:8];
  assign rnd_rot = {rnd[3:0], rnd[7:4]};

  always_comb begin
    cand_x = XW'(32'(rnd) % ROWS);
    cand_y = YW'(32'(rnd_rot) % COLUMNS);
    case (traffic_mode_e'(ModeSel))
      TRANSPOSE: begin
        cand_x = XW'(YADDR);
        cand_y = YW'(XADDR);
      end
      HOTSPOT: begin
        if (rnd[1:0] == 2'b00) begin
          cand_x = HotX;
          cand_y = HotY;
        end
      end
      FIXED: begin
        cand_x = HotX;
        cand_y = HotY;
      end
      default: ;
    endcase
  end

  // 9-bit compare makes INJ_RATE=256 always true and 0 always false.
  assign inject    = ({1'b0, lfsr[7:0]} < RateThr);
  assign self_dest = (cand_x == SrcX) && (cand_y == SrcY);

  logic xfer, last_flit, pkt_done, budget_hit, load_dest;
  state_e after_pkt;

  assign xfer       = o_transmit && i_send;
  assign last_flit  = (state_q == StHead) ? (PKT_LEN == 1) : (seq_q == LastSeq);
  assign pkt_done   = xfer && last_flit;
  assign budget_hit = (MAX_PKTS != 0) && ((pkts_q + 32'd1) == 32'(MAX_PKTS));
  assign after_pkt  = budget_hit ? StDone : (start_q ? StWait : StIdle);
  assign load_dest  = (state_q == StWait) && start_q && inject && !self_dest;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_q) state_d = StWait;
      StWait: begin
        if (!start_q) begin
          state_d = StIdle;
        end else if (load_dest) begin
          state_d = StHead;
        end
      end
      StHead, StBody: begin
        if (pkt_done) begin
          state_d = after_pkt;
        end else if (xfer) begin
          state_d = StBody;
        end
      end
      StDone: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_transmit = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_flit     = '0;
    unique case (state_q)
      StHead: begin
        o_transmit = 1'b1;
        o_busy     = 1'b1;
        o_flit     = {(PKT_LEN == 1) ? SINGLE : HEAD, dest_x_q, dest_y_q, SrcX, SrcY,
                      IdW'(pkt_id_q)};
      end
      StBody: begin
        o_transmit = 1'b1;
        o_busy     = 1'b1;
        o_flit[FLIT_W-1 -: 2]  = last_flit ? TAIL : BODY;
        o_flit[FLIT_W-3 -: 8]  = pkt_id_q[7:0];
        o_flit[FLIT_W-11 -: 8] = seq_q;
      end
      StDone: o_done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    dest_x_d = dest_x_q;
    dest_y_d = dest_y_q;
    pkt_id_d = pkt_id_q;
    seq_d    = seq_q;
    pkts_d   = pkts_q;
    flits_d  = flits_q;
    stall_d  = stall_q;
    if (load_dest) begin
      dest_x_d = cand_x;
      dest_y_d = cand_y;
    end
    if (xfer) begin
      seq_d   = (state_q == StHead) ? 8'd1 : seq_q + 8'd1;
      flits_d = (flits_q == '1) ? flits_q : flits_q + 32'd1;
    end
    if (pkt_done) begin
      seq_d    = '0;
      pkt_id_d = pkt_id_q + 16'd1;
      pkts_d   = (pkts_q == '1) ? pkts_q : pkts_q + 32'd1;
    end
    if (o_transmit && !i_send) begin
      stall_d = (stall_q == '1) ? stall_q : stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q  <= 1'b0;
      dest_x_q <= '0;
      dest_y_q <= '0;
      pkt_id_q <= '0;
      seq_q    <= '0;
      pkts_q   <= '0;
      flits_q  <= '0;
      stall_q  <= '0;
    end else begin
      start_q  <= i_start;
      dest_x_q <= dest_x_d;
      dest_y_q <= dest_y_d;
      pkt_id_q <= pkt_id_d;
      seq_q    <= seq_d;
      pkts_q   <= pkts_d;
      flits_q  <= flits_d;
      stall_q  <= stall_d;
    end
  end

  assign o_pkts_sent    = pkts_q;
  assign o_flits_sent   = flits_q;
  assign o_stall_cycles = stall_q;

endmodule

// File: tb/tb_traffic_gen_param.sv
// Bench for traffic_gen_param. Four instances:
//   A: fixed dest (2,3), node (0,0), 4-flit packets, always inject (model-checked)
//   B: single-flit packets, budget of 3
//   C: transpose at diagonal node (1,1), must never inject
//   D: transpose at node (1,2), every head goes to (2,1)
module tb_traffic_gen_param;

  localparam int unsigned A_LEN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic rst;
  logic rst_a_x, rst_a;
  logic start_a, send_a, start_b, send_b, start_c, send_c;
  assign rst_a = rst | rst_a_x;

  logic [31:0] a_flit, a_pkts, a_flits, a_stall;
  logic        a_tx, a_busy, a_done;
  logic [31:0] b_flit, b_pkts, b_flits, b_stall;
  logic        b_tx, b_busy, b_done;
  logic [31:0] c_flit, c_pkts, c_flits, c_stall;
  logic        c_tx, c_busy, c_done;
  logic [31:0] d_flit, d_pkts, d_flits, d_stall;
  logic        d_tx, d_busy, d_done;

  traffic_gen_param #(
    .MODE(3), .HOT_X(2), .HOT_Y(3), .PKT_LEN(A_LEN), .INJ_RATE(256)
  ) u_a (
    .clk(clk), .reset(rst_a), .i_start(start_a), .i_send(send_a),
    .o_flit(a_flit), .o_transmit(a_tx), .o_busy(a_busy), .o_done(a_done),
    .o_pkts_sent(a_pkts), .o_flits_sent(a_flits), .o_stall_cycles(a_stall)
  );

  traffic_gen_param #(
    .MODE(3), .HOT_X(2), .HOT_Y(3), .PKT_LEN(1), .INJ_RATE(256), .MAX_PKTS(3)
  ) u_b (
    .clk(clk), .reset(rst), .i_start(start_b), .i_send(send_b),
    .o_flit(b_flit), .o_transmit(b_tx), .o_busy(b_busy), .o_done(b_done),
    .o_pkts_sent(b_pkts), .o_flits_sent(b_flits), .o_stall_cycles(b_stall)
  );

  traffic_gen_param #(
    .MODE(1), .XADDR(1), .YADDR(1), .PKT_LEN(4), .INJ_RATE(256)
  ) u_c (
    .clk(clk), .reset(rst), .i_start(start_c), .i_send(send_c),
    .o_flit(c_flit), .o_transmit(c_tx), .o_busy(c_busy), .o_done(c_done),
    .o_pkts_sent(c_pkts), .o_flits_sent(c_flits), .o_stall_cycles(c_stall)
  );

  traffic_gen_param #(
    .MODE(1), .XADDR(1), .YADDR(2), .PKT_LEN(2), .INJ_RATE(64)
  ) u_d (
    .clk(clk), .reset(rst), .i_start(start_c), .i_send(send_c),
    .o_flit(d_flit), .o_transmit(d_tx), .o_busy(d_busy), .o_done(d_done),
    .o_pkts_sent(d_pkts), .o_flits_sent(d_flits), .o_stall_cycles(d_stall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_a(input int max_cycles, input string name);
    int k;
    k = 0;
    while (!a_tx && k < max_cycles) begin
      tick();
      k++;
    end
    check1(name, a_tx, 1'b1);
  endtask

  // Instance A model: flit idx 0 is the head to (2,3) from (0,0); idx 1..3 carry
  // pkt_id[7:0] and seq, idx 3 typed tail.
  function automatic logic [31:0] a_exp_flit(input int unsigned pkt, input int unsigned idx);
    logic [1:0] ty;
    logic [7:0] id8;
    logic [7:0] s8;
    if (idx == 0) return {2'b01, 2'd2, 2'd3, 2'd0, 2'd0, 22'(pkt)};
    ty  = (idx == A_LEN - 1) ? 2'b10 : 2'b00;
    id8 = 8'(pkt);
    s8  = 8'(idx);
    return {ty, id8, s8, 14'd0};
  endfunction

  int unsigned m_pkt = 0, m_idx = 0, m_flits = 0, m_pkts = 0, m_stall = 0;
  logic m_prev_tx = 1'b0, m_prev_xfer = 1'b0, m_prev_rst = 1'b1;
  bit   mon_a = 1'b0;

  always @(negedge clk) begin
    if (mon_a) begin
      if (m_prev_tx && !m_prev_xfer && !m_prev_rst) check1("a_tx_held", a_tx, 1'b1);
      if (a_tx) check("a_flit", a_flit, a_exp_flit(m_pkt, m_idx));
      check1("a_done_never", a_done, 1'b0);
      check("a_flits_sent", a_flits, m_flits);
      check("a_pkts_sent", a_pkts, m_pkts);
      check("a_stall_cycles", a_stall, m_stall);
      m_prev_tx   = a_tx;
      m_prev_xfer = a_tx && send_a;
      m_prev_rst  = rst_a;
      if (rst_a) begin
        m_pkt = 0; m_idx = 0; m_flits = 0; m_pkts = 0; m_stall = 0;
      end else begin
        if (a_tx && send_a) begin
          m_flits++;
          m_idx++;
          if (m_idx == A_LEN) begin
            m_idx = 0;
            m_pkt++;
            m_pkts++;
          end
        end
        if (a_tx && !send_a) m_stall++;
      end
    end
  end

  bit fin_a = 0, fin_b = 0, fin_cd = 0;

  // Instance A directed sequence.
  initial begin
    rst = 1'b1; rst_a_x = 1'b0;
    start_a = 1'b0; send_a = 1'b1;
    start_b = 1'b0; send_b = 1'b1;
    start_c = 1'b0; send_c = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_a = 1'b1;
    check1("a_rst_tx", a_tx, 1'b0);
    check1("a_rst_busy", a_busy, 1'b0);
    check1("a_rst_done", a_done, 1'b0);
    check("a_rst_flit", a_flit, 32'h0);
    check("a_rst_pkts", a_pkts, 32'h0);

    start_a = 1'b1;
    tick(); check1("a_lat_n0", a_tx, 1'b0);
    tick(); check1("a_lat_n1", a_tx, 1'b0);
    tick(); check1("a_lat_n2", a_tx, 1'b1);
    check("a_head0", a_flit, 32'h6C00_0000);
    check1("a_busy_head", a_busy, 1'b1);
    tick(); check("a_body1", a_flit, 32'h0000_4000);
    tick(); check("a_body2", a_flit, 32'h0000_8000);
    tick(); check("a_tail0", a_flit, 32'h8000_C000);
    tick();
    check("a_pkts_after_tail", a_pkts, 32'd1);
    check("a_flits_after_tail", a_flits, 32'd4);
    check1("a_gap_tx", a_tx, 1'b0);
    tick(); check("a_head1", a_flit, 32'h6C00_0001);

    // Stall on the first body flit for two cycles.
    tick(); check("a_p1_body1", a_flit, 32'h0040_4000);
    send_a = 1'b0;
    tick(); check("a_stall_hold1", a_flit, 32'h0040_4000);
    tick(); check("a_stall_hold2", a_flit, 32'h0040_4000);
    check("a_stall_count", a_stall, 32'd2);
    send_a = 1'b1;
    tick(); check("a_p1_body2", a_flit, 32'h0040_8000);
    start_a = 1'b0;
    tick(); check("a_p1_tail", a_flit, 32'h8040_C000);
    tick();
    check1("a_idle_tx", a_tx, 1'b0);
    check1("a_idle_busy", a_busy, 1'b0);
    check("a_pkts_two", a_pkts, 32'd2);
    check("a_flits_eight", a_flits, 32'd8);
    repeat (5) tick();
    check1("a_idle_stays", a_tx, 1'b0);

    // Reset in the middle of packet 2's body.
    start_a = 1'b1;
    wait_tx_a(10, "a_restart_tx");
    check("a_head2", a_flit, 32'h6C00_0002);
    tick(); check("a_p2_body1", a_flit, 32'h0080_4000);
    rst_a_x = 1'b1;
    start_a = 1'b0;
    tick();
    rst_a_x = 1'b0;
    check1("a_mrst_tx", a_tx, 1'b0);
    check1("a_mrst_busy", a_busy, 1'b0);
    check1("a_mrst_done", a_done, 1'b0);
    check("a_mrst_flit", a_flit, 32'h0);
    check("a_mrst_pkts", a_pkts, 32'h0);
    check("a_mrst_flits", a_flits, 32'h0);
    check("a_mrst_stall", a_stall, 32'h0);

    start_a = 1'b1;
    wait_tx_a(10, "a_rerun_tx");
    check("a_rerun_head", a_flit, 32'h6C00_0000);
    tick(); check("a_rerun_body1", a_flit, 32'h0000_4000);
    tick(); check("a_rerun_body2", a_flit, 32'h0000_8000);
    tick(); check("a_rerun_tail", a_flit, 32'h8000_C000);
    start_a = 1'b0;
    tick(); check("a_rerun_pkts", a_pkts, 32'd1);
    repeat (3) tick();
    fin_a = 1'b1;
  end

  // Instance B: budget of three single-flit packets, then sticky done.
  logic [31:0] b_got[$];

  initial begin
    int bad;
    wait (rst == 1'b0);
    start_b = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (b_tx && send_b) b_got.push_back(b_flit);
    end
    check("b_flit_count", 32'(b_got.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < b_got.size()) check("b_single", b_got[i], 32'hEC00_0000 | 32'(i));
    end
    #1;
    check1("b_done", b_done, 1'b1);
    check1("b_done_tx", b_tx, 1'b0);
    check("b_pkts", b_pkts, 32'd3);
    check("b_flits", b_flits, 32'd3);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      start_b = k[0];
      tick();
      if (b_tx || !b_done) bad++;
    end
    check("b_done_sticky", 32'(bad), 32'd0);
    check("b_pkts_final", b_pkts, 32'd3);
    fin_b = 1'b1;
  end

  // Instances C and D: transpose pattern.
  initial begin
    int c_tx_cycles;
    logic [31:0] d_next_id;
    c_tx_cycles = 0;
    d_next_id   = '0;
    wait (rst == 1'b0);
    start_c = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (c_tx) c_tx_cycles++;
      if (d_tx && d_flit[31:30] == 2'b01) begin
        check("d_head", d_flit, 32'h6580_0000 | d_next_id);
        d_next_id++;
      end
    end
    check("c_never_tx", 32'(c_tx_cycles), 32'd0);
    check("c_pkts", c_pkts, 32'd0);
    check1("d_heads_seen", d_next_id != 0, 1'b1);
    fin_cd = 1'b1;
  end

  initial begin
    wait (fin_a && fin_b && fin_cd);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/traffic_gen_param.md
Name: traffic_gen_param

Overview:
- Parametrised synthetic-traffic source for the LOCAL port of one mesh router.
- Injects multi-flit packets under on/off flow control.
- Injection rate, packet length, destination pattern (uniform, transpose, hotspot, fixed), packet budget and LFSR seed are all configurable.
- Exposes counters so mesh benches can measure offered load and back-pressure without scoreboards.

Parameters:
- ROWS, 4, mesh rows; sizes the destination x field.
- COLUMNS, 4, mesh columns; sizes the destination y field.
- XADDR, 0, this node's row address.
- YADDR, 0, this node's column address.
- FLIT_W, 32, flit width; must be >= 2+2*XW+2*YW+8 and >= 18.
- PKT_LEN, 4, flits per packet; 1..255.
- INJ_RATE, 64, injection probability per decision cycle = INJ_RATE/256; 0..256.
- MODE, 0, destination pattern: 0 uniform, 1 transpose, 2 hotspot, 3 fixed.
- HOT_X, 0, row of the hotspot/fixed destination.
- HOT_Y, 0, column of the hotspot/fixed destination.
- MAX_PKTS, 0, packet budget; 0 = unlimited.
- SEED, 16'hACE1, LFSR seed; value 0 is replaced by 16'hACE1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_start  in  1  level; high permits new packets.
- i_send  in  1  router on/off: high = LOCAL input can accept a flit this cycle.
- o_flit  out  FLIT_W  current flit.
- o_transmit  out  1  o_flit valid (request).
- o_busy  out  1  packet in progress (HEAD/BODY).
- o_done  out  1  MAX_PKTS packets fully sent.
- o_pkts_sent  out  32  completed packets.
- o_flits_sent  out  32  transferred flits.
- o_stall_cycles  out  32  cycles with o_transmit=1 and i_send=0.

Behaviour:
- Widths: XW = max(1,$clog2(ROWS)), YW = max(1,$clog2(COLUMNS)).
- Flit type field is [FLIT_W-1:FLIT_W-2]: 01 head, 00 body, 10 tail, 11 single (PKT_LEN=1).
- Head flit, packed below the type field MSB-first: dest_x, dest_y, src_x, src_y, then pkt_id zero-extended to fill.
- Body/tail flit: [FLIT_W-3:FLIT_W-10]=pkt_id[7:0], [FLIT_W-11:FLIT_W-18]=seq (1..PKT_LEN-1), remaining bits 0.
- Transfer rule: a flit transfers on a posedge where o_transmit=1 and i_send=1. o_flit is held stable while o_transmit=1 and not transferred. o_transmit never drops without a transfer, except on reset.
- LFSR: 16-bit Galois, mask 16'hB400, shifts every cycle the FSM is not in IDLE or DONE. Reset loads SEED (or ACE1 if SEED=0).
- FSM states: IDLE, WAIT, HEAD, BODY, DONE.
- IDLE -> WAIT when i_start=1.
- WAIT:
  - i_start=0 -> IDLE.
  - Otherwise inject when lfsr[7:0] < INJ_RATE; INJ_RATE=256 injects always, 0 never.
  - On inject, the destination is latched and the FSM goes to HEAD; if the candidate equals (XADDR,YADDR), stay in WAIT (retry next cycle).
  - MODE 0: dest_x = lfsr[15:8] % ROWS, dest_y = lfsr[15:8] % COLUMNS after a 4-bit rotate.
  - MODE 1: dest = (YADDR,XADDR); diagonal nodes therefore never inject.
  - MODE 2: if lfsr[9:8]==0 use (HOT_X,HOT_Y), else uniform.
  - MODE 3: always (HOT_X,HOT_Y).
- HEAD: o_transmit=1.
  - On transfer with PKT_LEN=1, the packet completes.
  - On transfer with PKT_LEN>1 -> BODY, seq=1.
- BODY: o_transmit=1. On each transfer seq++. The flit with seq=PKT_LEN-1 is typed tail; its transfer completes the packet.
- Packet completion:
  - o_pkts_sent++, pkt_id++ (wraps at 2^16).
  - If MAX_PKTS!=0 and o_pkts_sent+1==MAX_PKTS -> DONE.
  - Else -> WAIT if i_start=1, else IDLE.
- i_start deasserted mid-packet: the packet still completes; no truncation.
- DONE: o_done=1, o_transmit=0. The FSM stays in DONE regardless of i_start; only reset exits it.
- Latency: i_start sampled high at edge N; with INJ_RATE=256 and a legal destination, the head is presented (o_transmit=1) after edge N+2.
- Counters saturate at 2^32-1.
- o_busy=1 in HEAD/BODY.
- Reset (any cycle, including mid-packet):
  - state=IDLE, o_transmit=0, o_flit=0, o_busy=0, o_done=0.
  - All counters=0, pkt_id=0, seq=0, LFSR=seed.
  - A partial packet is abandoned.

Decomposition:
- router_pkg gains:
  - flit_type_e (HEAD=2'b01, BODY=2'b00, TAIL=2'b10, SINGLE=2'b11).
  - traffic_mode_e (UNIFORM, TRANSPOSE, HOTSPOT, FIXED).
  - LFSR_MASK=16'hB400.
  - LFSR_DEFAULT_SEED=16'hACE1.
- One sub-module, tg_lfsr16: seed parameter, enable input, 16-bit state output, synchronous reset.
- FSM, flit packing and counters stay in traffic_gen_param.

Test Plan:
- MODE=3, HOT=(2,3), node (0,0), PKT_LEN=4, INJ_RATE=256, i_send=1 -> head at edge N+2 with dest (2,3) src (0,0) pkt_id 0. Then body seq1, body seq2, tail seq3 on consecutive cycles. o_pkts_sent=1 after tail.
- Same config, i_send toggles 1,0,0,1 -> o_flit stable across stalls; o_stall_cycles=2; flit order unchanged.
- PKT_LEN=1, MAX_PKTS=3 -> three type-11 flits with pkt_id 0,1,2; then o_done=1, o_transmit=0. Toggling i_start does not restart.
- MODE=1 at node (1,1) -> o_transmit never asserts in 1000 cycles. Node (1,2) -> every head has dest (2,1).
- i_start dropped during body of pkt 0 -> remaining flits and tail sent; FSM returns to IDLE; o_pkts_sent=1.
- Reset asserted during BODY -> next cycle all outputs 0. After re-start, the flit sequence is identical to the first run (same seed).
